node_injector: RTL and testbench

NODE_INJECTOR -- requirements
Module: node_injector

---
 rtl/node_injector_if.sv | 27 ++
 rtl/node_injector.sv | 123 ++++++++++++
 tb/tb_node_injector.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/node_injector_if.sv
// Packet-request, body-word, router-channel and credit signals shared by the
// injector and whatever feeds it.
interface node_injector_if #(
    parameter int flit_data_width = 64
) ();
    logic                       pkt_valid;
    logic                       pkt_ready;
    logic [3:0]                 pkt_dest;
    logic [2:0]                 pkt_len;
    logic [1:0]                 pkt_vc;
    logic                       data_valid;
    logic                       data_ready;
    logic [flit_data_width-1:0] data;
    logic [flit_data_width+5:0] channel_out;
    logic [2:0]                 flow_ctrl_in;
    logic                       error;

    modport slave (
        input  pkt_valid, pkt_dest, pkt_len, pkt_vc, data_valid, data, flow_ctrl_in,
        output pkt_ready, data_ready, channel_out, error
    );

    modport master (
        output pkt_valid, pkt_dest, pkt_len, pkt_vc, data_valid, data, flow_ctrl_in,
        input  pkt_ready, data_ready, channel_out, error
    );
endinterface

// File: rtl/node_injector.sv
// Network-interface injector: turns packet requests plus body words into
// head/body/tail flits on one router input channel under per-VC credit flow control.
module node_injector #(
    parameter int flit_data_width    = 64,
    parameter int credits_per_vc     = 16,
    parameter int max_payload_length = 4
) (
    input logic            clk,
    input logic            reset,
    node_injector_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HEAD = 2'd1;
    localparam logic [1:0] BODY = 2'd2;
    localparam int         CW   = flit_data_width + 6;
    localparam logic [4:0] CREDIT_MAX = 5'(credits_per_vc);

    logic [1:0]    state;
    logic [3:0]    dest_q;
    logic [2:0]    len_q;
    logic [1:0]    vc_q;
    logic [2:0]    count_q;
    logic [4:0]    credit      [4];
    logic [4:0]    credit_next [4];
    logic          error_q;
    logic          overflow;
    logic [CW-1:0] channel_q;
    logic [CW-1:0] flit_next;
    logic [3:0]    inc_vec;
    logic [3:0]    dec_vec;
    logic          has_credit;
    logic          emit_head;
    logic          emit_body;
    logic          last_body;
    logic          len_bad;

    assign has_credit = credit[vc_q] != '0;
    assign emit_head  = (state == HEAD) && has_credit;
    assign emit_body  = (state == BODY) && has_credit && bus.data_valid;
    assign last_body  = (count_q + 3'd1) == len_q;
    assign len_bad    = 32'(bus.pkt_len) > max_payload_length;

    assign inc_vec = bus.flow_ctrl_in[0] ? (4'b0001 << bus.flow_ctrl_in[2:1]) : 4'b0000;
    assign dec_vec = (emit_head || emit_body) ? (4'b0001 << vc_q) : 4'b0000;

    assign bus.pkt_ready   = (state == IDLE);
    assign bus.data_ready  = (state == BODY) && has_credit;
    assign bus.channel_out = channel_q;
    assign bus.error       = error_q;

    always_comb begin
        flit_next = '0;
        if (emit_head) begin
            flit_next[0]     = 1'b1;
            flit_next[2:1]   = vc_q;
            flit_next[3]     = 1'b1;
            flit_next[4]     = (len_q == 3'd0);
            flit_next[9:6]   = dest_q;
            flit_next[12:10] = len_q;
        end else if (emit_body) begin
            flit_next[0]      = 1'b1;
            flit_next[2:1]    = vc_q;
            flit_next[4]      = last_body;
            flit_next[CW-1:6] = bus.data;
        end
    end

    // A return and a send on the same VC cancel, so they never trip saturation.
    always_comb begin
        overflow = 1'b0;
        for (int unsigned v = 0; v < 4; v++) begin
            credit_next[v] = credit[v];
            if (inc_vec[v] && !dec_vec[v]) begin
                if (credit[v] >= CREDIT_MAX) overflow = 1'b1;
                else                         credit_next[v] = credit[v] + 5'd1;
            end else if (dec_vec[v] && !inc_vec[v]) begin
                credit_next[v] = credit[v] - 5'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            dest_q    <= '0;
            len_q     <= '0;
            vc_q      <= '0;
            count_q   <= '0;
            error_q   <= 1'b0;
            channel_q <= '0;
            for (int unsigned v = 0; v < 4; v++) credit[v] <= CREDIT_MAX;
        end else begin
            credit    <= credit_next;
            channel_q <= flit_next;
            if (overflow) error_q <= 1'b1;
            case (state)
                IDLE: begin
                    if (bus.pkt_valid) begin
                        if (len_bad) begin
                            error_q <= 1'b1;
                        end else begin
                            dest_q  <= bus.pkt_dest;
                            len_q   <= bus.pkt_len;
                            vc_q    <= bus.pkt_vc;
                            count_q <= '0;
                            state   <= HEAD;
                        end
                    end
                end
                HEAD: begin
                    if (emit_head) state <= (len_q == 3'd0) ? IDLE : BODY;
                end
                BODY: begin
                    if (emit_body) begin
                        count_q <= count_q + 3'd1;
                        if (last_body) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_node_injector.sv
// Directed bench for node_injector: expected flits queued at stimulus time and
// matched against channel_out by a negedge monitor.
module tb_node_injector;
    logic clk = 1'b0;
    logic reset;
    int   vectors    = 0;
    int   miscompares = 0;
    int   cyc        = 0;

    logic [69:0] sb [$];
    int          flit_cyc [$];
    logic [69:0] exp_f;

    node_injector_if #(.flit_data_width(64)) bus ();

    node_injector #(
        .flit_data_width(64),
        .credits_per_vc(16),
        .max_payload_length(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [69:0] mk_head(logic [3:0] d, logic [2:0] l, logic [1:0] v);
        logic [69:0] f;
        f = '0;
        f[0] = 1'b1; f[2:1] = v; f[3] = 1'b1; f[4] = (l == 3'd0);
        f[9:6] = d; f[12:10] = l;
        return f;
    endfunction

    function automatic logic [69:0] mk_body(logic [63:0] w, logic [1:0] v, logic t);
        logic [69:0] f;
        f = '0;
        f[0] = 1'b1; f[2:1] = v; f[4] = t; f[69:6] = w;
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input logic [3:0] d, input logic [2:0] l, input logic [1:0] v);
        int n = 0;
        bus.pkt_valid = 1'b1; bus.pkt_dest = d; bus.pkt_len = l; bus.pkt_vc = v;
        while (!bus.pkt_ready && n < 100) begin tick(); n++; end
        chk("pkt_accept_wait", 70'(bus.pkt_ready), 70'd1);
        if (l <= 3'd4) sb.push_back(mk_head(d, l, v));
        tick();
        bus.pkt_valid = 1'b0;
    endtask

    task automatic send_body(input logic [63:0] w, input logic [1:0] v, input logic t);
        int n = 0;
        bus.data_valid = 1'b1; bus.data = w;
        while (!bus.data_ready && n < 100) begin tick(); n++; end
        chk("data_ready_wait", 70'(bus.data_ready), 70'd1);
        sb.push_back(mk_body(w, v, t));
        tick();
        bus.data_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (bus.channel_out[0]) begin
            flit_cyc.push_back(cyc);
            vectors++;
            assert (sb.size() != 0) else begin
                miscompares++;
                $error("FAIL unexpected_flit observed=%h expected=none", bus.channel_out);
            end
            if (sb.size() != 0) begin
                exp_f = sb.pop_front();
                chk("flit", bus.channel_out, exp_f);
            end
        end else begin
            chk("idle_zero", bus.channel_out, 70'd0);
        end
    end

    initial begin
        int f0;
        int acc;
        int cc;
        reset = 1'b0;
        bus.pkt_valid = 1'b0; bus.pkt_dest = '0; bus.pkt_len = '0; bus.pkt_vc = '0;
        bus.data_valid = 1'b0; bus.data = '0; bus.flow_ctrl_in = '0;
        repeat (2) tick();
        chk("rst_pkt_ready", 70'(bus.pkt_ready), 70'd1);
        chk("rst_data_ready", 70'(bus.data_ready), 70'd0);
        chk("rst_channel", bus.channel_out, 70'd0);
        chk("rst_error", 70'(bus.error), 70'd0);
        reset = 1'b1;
        tick();

        // dest 5, len 2, vc 1 with back-to-back body words
        f0 = flit_cyc.size();
        send_pkt(4'd5, 3'd2, 2'd1);
        acc = cyc;
        send_body(64'hA, 2'd1, 1'b0);
        send_body(64'hB, 2'd1, 1'b1);
        chk("idle_latency", 70'(cyc - acc), 70'd3);
        chk("ready_after_pkt", 70'(bus.pkt_ready), 70'd1);
        tick();
        chk("flit_count_a", 70'(flit_cyc.size() - f0), 70'd3);
        if (flit_cyc.size() >= f0 + 3)
            chk("consecutive", 70'(flit_cyc[f0+2] - flit_cyc[f0]), 70'd2);
        chk("credit1", 70'(dut.credit[1]), 70'd13);

        // zero-length packet
        send_pkt(4'd3, 3'd0, 2'd3);
        chk("len0_in_head", 70'(bus.pkt_ready), 70'd0);
        tick();
        chk("len0_idle", 70'(bus.pkt_ready), 70'd1);
        tick();

        // exhaust vc 0 credits
        f0 = flit_cyc.size();
        for (int k = 0; k < 17; k++) send_pkt(4'(k), 3'd0, 2'd0);
        repeat (3) tick();
        chk("stall_count", 70'(flit_cyc.size() - f0), 70'd16);
        chk("stall_ready", 70'(bus.pkt_ready), 70'd0);
        bus.flow_ctrl_in = 3'b001;
        tick();
        bus.flow_ctrl_in = 3'b000;
        cc = cyc;
        repeat (2) tick();
        chk("release_count", 70'(flit_cyc.size() - f0), 70'd17);
        chk("release_time", 70'(flit_cyc[flit_cyc.size()-1]), 70'(cc + 1));
        chk("release_ready", 70'(bus.pkt_ready), 70'd1);

        // credit return coinciding with a send on vc 2, then overflow
        send_pkt(4'd9, 3'd1, 2'd2);
        bus.flow_ctrl_in = 3'b101;
        tick();
        bus.flow_ctrl_in = 3'b000;
        chk("credit2_same", 70'(dut.credit[2]), 70'd16);
        chk("no_err_same", 70'(bus.error), 70'd0);
        send_body(64'h1234_5678_9abc_def0, 2'd2, 1'b1);
        chk("credit2_dec", 70'(dut.credit[2]), 70'd15);
        bus.flow_ctrl_in = 3'b101;
        tick();
        chk("credit2_full", 70'(dut.credit[2]), 70'd16);
        chk("no_err_full", 70'(bus.error), 70'd0);
        tick();
        bus.flow_ctrl_in = 3'b000;
        chk("overflow_err", 70'(bus.error), 70'd1);
        chk("credit2_sat", 70'(dut.credit[2]), 70'd16);
        repeat (3) tick();
        chk("err_sticky", 70'(bus.error), 70'd1);

        reset = 1'b0;
        #1;
        chk("err_cleared", 70'(bus.error), 70'd0);
        reset = 1'b1;
        tick();

        // oversize packet dropped
        f0 = flit_cyc.size();
        send_pkt(4'd2, 3'd7, 2'd1);
        chk("drop_idle", 70'(bus.pkt_ready), 70'd1);
        chk("drop_err", 70'(bus.error), 70'd1);
        repeat (3) tick();
        chk("drop_no_flit", 70'(flit_cyc.size() - f0), 70'd0);

        // reset while a body flit is on the channel
        send_pkt(4'd6, 3'd3, 2'd0);
        send_body(64'h11, 2'd0, 1'b0);
        bus.data_valid = 1'b1; bus.data = 64'h22;
        tick();
        bus.data_valid = 1'b0;
        chk("body_before_rst", bus.channel_out, mk_body(64'h22, 2'd0, 1'b0));
        #2 reset = 1'b0;
        #1;
        chk("rst_mid_channel", bus.channel_out, 70'd0);
        chk("rst_mid_ready", 70'(bus.pkt_ready), 70'd1);
        chk("rst_mid_dready", 70'(bus.data_ready), 70'd0);
        chk("rst_mid_error", 70'(bus.error), 70'd0);
        for (int v = 0; v < 4; v++) chk("rst_mid_credit", 70'(dut.credit[v]), 70'd16);
        reset = 1'b1;
        tick();
        f0 = flit_cyc.size();
        send_pkt(4'd7, 3'd0, 2'd2);
        repeat (2) tick();
        chk("post_rst_flits", 70'(flit_cyc.size() - f0), 70'd1);
        chk("scoreboard_empty", 70'(sb.size()), 70'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
